// File: rtl/mips_defs.sv
// Shared MIPS datapath definitions: default widths and load-filter codes.
package mips_defs;

  localparam int NBITS  = 32;
  localparam int NB_REG = 5;

  // Codes 3'b110 and 3'b111 are unnamed and behave like LOAD_LW.
  typedef enum logic [2:0] {
    LOAD_LW  = 3'b000,
    LOAD_LB  = 3'b001,
    LOAD_LBU = 3'b010,
    LOAD_LH  = 3'b011,
    LOAD_LHU = 3'b100,
    LOAD_LUI = 3'b101
  } load_type_e;

endpackage

// File: rtl/load_filter.sv
// Combinational little-endian load filter: selects and extends the byte,
// halfword or word of a raw data-memory read, or builds the LUI result.
module load_filter #(
  parameter int NBITS = mips_defs::NBITS
) (
  input  logic [NBITS-1:0] i_raw_data,
  input  logic [2:0]       i_load_type,
  input  logic [1:0]       i_byte_offset,
  input  logic [15:0]      i_imm16,
  output logic [NBITS-1:0] o_data
);
  import mips_defs::*;

  logic [7:0]  selByte;
  logic [15:0] selHalf;

  always_comb begin
    selByte = i_raw_data[7:0];
    case (i_byte_offset)
      2'd0: selByte = i_raw_data[7:0];
      2'd1: selByte = i_raw_data[15:8];
      2'd2: selByte = i_raw_data[23:16];
      2'd3: selByte = i_raw_data[31:24];
      default: selByte = i_raw_data[7:0];
    endcase
    // Halfwords are chosen by offset[1] only; no misalignment trap.
    selHalf = i_byte_offset[1] ? i_raw_data[31:16] : i_raw_data[15:0];

    o_data = i_raw_data;
    case (load_type_e'(i_load_type))
      LOAD_LB:  o_data = {{(NBITS-8){selByte[7]}}, selByte};
      LOAD_LBU: o_data = NBITS'(selByte);
      LOAD_LH:  o_data = {{(NBITS-16){selHalf[15]}}, selHalf};
      LOAD_LHU: o_data = NBITS'(selHalf);
      LOAD_LUI: o_data = NBITS'({i_imm16, 16'h0000});
      default:  o_data = i_raw_data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register feeding the write-back MemToReg mux, with
// debug stepping, flush, sticky HALT and a retired-instruction counter.
module mem_wb_stage #(
  parameter int NBITS  = mips_defs::NBITS,
  parameter int NB_REG = mips_defs::NB_REG,
  parameter int NB_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic              i_RegWrite,
  input  logic              i_MemToReg,
  input  logic              i_jal,
  input  logic              i_halt,
  input  logic [NB_REG-1:0] i_rd_addr,
  input  logic [2:0]        i_load_type,
  input  logic [1:0]        i_byte_offset,
  input  logic [15:0]       i_imm16,
  input  logic [NBITS-1:0]  i_raw_mem_data,
  input  logic [NBITS-1:0]  i_ALU_result,
  output logic              o_valid,
  output logic              o_RegWrite,
  output logic              o_MemToReg,
  output logic              o_jal,
  output logic [NB_REG-1:0] o_rd_addr,
  output logic [NBITS-1:0]  o_MemData,
  output logic [NBITS-1:0]  o_ALU_result,
  output logic              o_halt,
  output logic [NB_CNT-1:0] o_retired_count
);
  import mips_defs::*;

  logic [NBITS-1:0] filtered;

  logic              valid_q, valid_d;
  logic              regWrite_q, regWrite_d;
  logic              memToReg_q, memToReg_d;
  logic              jal_q, jal_d;
  logic              halt_q, halt_d;
  logic [NB_REG-1:0] rdAddr_q, rdAddr_d;
  logic [NBITS-1:0]  memData_q, memData_d;
  logic [NBITS-1:0]  aluResult_q, aluResult_d;
  logic [NB_CNT-1:0] count_q, count_d;

  load_filter #(.NBITS(NBITS)) u_load_filter (
    .i_raw_data    (i_raw_mem_data),
    .i_load_type   (i_load_type),
    .i_byte_offset (i_byte_offset),
    .i_imm16       (i_imm16),
    .o_data        (filtered)
  );

  // Bubbles clear only the control bits; data and address keep their values.
  always_comb begin
    valid_d     = valid_q;
    regWrite_d  = regWrite_q;
    memToReg_d  = memToReg_q;
    jal_d       = jal_q;
    halt_d      = halt_q;
    rdAddr_d    = rdAddr_q;
    memData_d   = memData_q;
    aluResult_d = aluResult_q;
    count_d     = count_q;
    if (halt_q || i_flush) begin
      valid_d    = 1'b0;
      regWrite_d = 1'b0;
      memToReg_d = 1'b0;
      jal_d      = 1'b0;
    end else if (i_enable) begin
      valid_d     = i_valid;
      regWrite_d  = i_RegWrite & i_valid;
      memToReg_d  = i_MemToReg & i_valid;
      jal_d       = i_jal & i_valid;
      halt_d      = i_halt & i_valid;
      rdAddr_d    = i_rd_addr;
      memData_d   = filtered;
      aluResult_d = i_ALU_result;
      if (i_valid) count_d = count_q + NB_CNT'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q     <= 1'b0;
      regWrite_q  <= 1'b0;
      memToReg_q  <= 1'b0;
      jal_q       <= 1'b0;
      halt_q      <= 1'b0;
      rdAddr_q    <= '0;
      memData_q   <= '0;
      aluResult_q <= '0;
      count_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      regWrite_q  <= regWrite_d;
      memToReg_q  <= memToReg_d;
      jal_q       <= jal_d;
      halt_q      <= halt_d;
      rdAddr_q    <= rdAddr_d;
      memData_q   <= memData_d;
      aluResult_q <= aluResult_d;
      count_q     <= count_d;
    end
  end

  assign o_valid         = valid_q;
  assign o_RegWrite      = regWrite_q;
  assign o_MemToReg      = memToReg_q;
  assign o_jal           = jal_q;
  assign o_halt          = halt_q;
  assign o_rd_addr       = rdAddr_q;
  assign o_MemData       = memData_q;
  assign o_ALU_result    = aluResult_q;
  assign o_retired_count = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; a second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap-around.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, enable, flush, valid, regWrite, memToReg, jal, halt;
  logic [4:0]  rdAddr;
  logic [2:0]  loadType;
  logic [1:0]  byteOffset;
  logic [15:0] imm16;
  logic [31:0] rawData, aluResult;

  logic        oValid, oRegWrite, oMemToReg, oJal, oHalt;
  logic [4:0]  oRdAddr;
  logic [31:0] oMemData, oAluResult, oCount;

  logic        wValid, wRegWrite, wMemToReg, wJal, wHalt;
  logic [4:0]  wRdAddr;
  logic [31:0] wMemData, wAluResult;
  logic [3:0]  wCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_flush(flush),
    .i_valid(valid), .i_RegWrite(regWrite), .i_MemToReg(memToReg),
    .i_jal(jal), .i_halt(halt), .i_rd_addr(rdAddr), .i_load_type(loadType),
    .i_byte_offset(byteOffset), .i_imm16(imm16), .i_raw_mem_data(rawData),
    .i_ALU_result(aluResult), .o_valid(oValid), .o_RegWrite(oRegWrite),
    .o_MemToReg(oMemToReg), .o_jal(oJal), .o_rd_addr(oRdAddr),
    .o_MemData(oMemData), .o_ALU_result(oAluResult), .o_halt(oHalt),
    .o_retired_count(oCount)
  );

  mem_wb_stage #(.NB_CNT(4)) dutWrap (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_flush(flush),
    .i_valid(valid), .i_RegWrite(regWrite), .i_MemToReg(memToReg),
    .i_jal(jal), .i_halt(halt), .i_rd_addr(rdAddr), .i_load_type(loadType),
    .i_byte_offset(byteOffset), .i_imm16(imm16), .i_raw_mem_data(rawData),
    .i_ALU_result(aluResult), .o_valid(wValid), .o_RegWrite(wRegWrite),
    .o_MemToReg(wMemToReg), .o_jal(wJal), .o_rd_addr(wRdAddr),
    .o_MemData(wMemData), .o_ALU_result(wAluResult), .o_halt(wHalt),
    .o_retired_count(wCount)
  );

  // Advance one rising edge and settle 1 time unit past it before checking.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic setOp(input logic v, input logic rw, input logic m2r,
                       input logic j, input logic h, input logic [4:0] rd,
                       input logic [31:0] alu);
    valid = v; regWrite = rw; memToReg = m2r; jal = j; halt = h;
    rdAddr = rd; aluResult = alu;
  endtask

  task automatic setLoad(input logic [2:0] lt, input logic [1:0] off);
    loadType = lt; byteOffset = off;
  endtask

  initial begin
    // Reset with arbitrary, busy inputs for two cycles.
    reset = 1'b1; enable = 1'b1; flush = 1'b0; imm16 = 16'h1357;
    rawData = 32'hCAFE_F00D;
    setOp(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd17, 32'hFFFF_0000);
    setLoad(3'b001, 2'd2);
    applyStimulus();
    applyStimulus();
    checkOutput("rst_valid",    32'(oValid),     32'd0);
    checkOutput("rst_regwrite", 32'(oRegWrite),  32'd0);
    checkOutput("rst_memtoreg", 32'(oMemToReg),  32'd0);
    checkOutput("rst_jal",      32'(oJal),       32'd0);
    checkOutput("rst_rd",       32'(oRdAddr),    32'd0);
    checkOutput("rst_memdata",  oMemData,        32'd0);
    checkOutput("rst_alu",      oAluResult,      32'd0);
    checkOutput("rst_halt",     32'(oHalt),      32'd0);
    checkOutput("rst_count",    oCount,          32'd0);
    checkOutput("rst_wcount",   32'(wCount),     32'd0);

    // First valid ALU op after release.
    reset = 1'b0;
    setOp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_1234);
    setLoad(3'b000, 2'd0);
    rawData = 32'h0;
    applyStimulus();
    checkOutput("alu_valid",    32'(oValid),    32'd1);
    checkOutput("alu_rd",       32'(oRdAddr),   32'd5);
    checkOutput("alu_result",   oAluResult,     32'h0000_1234);
    checkOutput("alu_regwrite", 32'(oRegWrite), 32'd1);
    checkOutput("alu_count",    oCount,         32'd1);

    // Load filter sweep on raw word 0x80FF_7F01.
    rawData = 32'h80FF_7F01; imm16 = 16'hABCD;
    setOp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 32'h0000_0040);
    setLoad(3'b001, 2'd3); applyStimulus();
    checkOutput("lb_off3",  oMemData, 32'hFFFF_FF80);
    checkOutput("lb_m2r",   32'(oMemToReg), 32'd1);
    setLoad(3'b010, 2'd1); applyStimulus();
    checkOutput("lbu_off1", oMemData, 32'h0000_007F);
    setLoad(3'b011, 2'd2); applyStimulus();
    checkOutput("lh_off2",  oMemData, 32'hFFFF_80FF);
    setLoad(3'b100, 2'd0); applyStimulus();
    checkOutput("lhu_off0", oMemData, 32'h0000_7F01);
    setLoad(3'b000, 2'd3); applyStimulus();
    checkOutput("lw",       oMemData, 32'h80FF_7F01);
    setLoad(3'b111, 2'd1); applyStimulus();
    checkOutput("code111",  oMemData, 32'h80FF_7F01);
    setLoad(3'b011, 2'd3); applyStimulus();
    checkOutput("lh_off3",  oMemData, 32'hFFFF_80FF);
    setLoad(3'b101, 2'd0); applyStimulus();
    checkOutput("lui",      oMemData, 32'hABCD_0000);
    checkOutput("load_count", oCount, 32'd9);

    // Hold for three cycles while the inputs change.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setOp(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'(20 + i), 32'hDEAD_0000 + 32'(i));
      setLoad(3'b000, 2'd0);
      applyStimulus();
      checkOutput("hold_rd",      32'(oRdAddr), 32'd10);
      checkOutput("hold_alu",     oAluResult,   32'h0000_0040);
      checkOutput("hold_memdata", oMemData,     32'hABCD_0000);
      checkOutput("hold_count",   oCount,       32'd9);
    end

    // Release with an invalid instruction: fields captured, controls gated.
    enable = 1'b1;
    setOp(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_DEAD);
    applyStimulus();
    checkOutput("rel_valid",    32'(oValid),    32'd0);
    checkOutput("rel_regwrite", 32'(oRegWrite), 32'd0);
    checkOutput("rel_jal",      32'(oJal),      32'd0);
    checkOutput("rel_rd",       32'(oRdAddr),   32'd9);
    checkOutput("rel_alu",      oAluResult,     32'h0000_DEAD);
    checkOutput("rel_memdata",  oMemData,       32'h80FF_7F01);
    checkOutput("rel_count",    oCount,         32'd9);

    // Flush while held: bubble, data kept, no count.
    setOp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0000_0055);
    applyStimulus();
    checkOutput("pre_flush_valid", 32'(oValid), 32'd1);
    enable = 1'b0; flush = 1'b1;
    setOp(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0066);
    applyStimulus();
    checkOutput("flush_valid",    32'(oValid),    32'd0);
    checkOutput("flush_regwrite", 32'(oRegWrite), 32'd0);
    checkOutput("flush_rd",       32'(oRdAddr),   32'd3);
    checkOutput("flush_alu",      oAluResult,     32'h0000_0055);
    checkOutput("flush_count",    oCount,         32'd10);

    // Flush beats a simultaneous valid HALT.
    enable = 1'b1;
    setOp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
    applyStimulus();
    checkOutput("flushhalt_halt",  32'(oHalt),  32'd0);
    checkOutput("flushhalt_valid", 32'(oValid), 32'd0);
    checkOutput("flushhalt_count", oCount,      32'd10);

    // Valid HALT is captured with o_valid=1, then the stage bubbles forever.
    flush = 1'b0;
    setOp(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 32'h0000_0100);
    applyStimulus();
    checkOutput("halt_flag",  32'(oHalt),  32'd1);
    checkOutput("halt_valid", 32'(oValid), 32'd1);
    checkOutput("halt_jal",   32'(oJal),   32'd1);
    checkOutput("halt_count", oCount,      32'd11);
    setOp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 32'h0000_0200);
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checkOutput("halted_valid", 32'(oValid),  32'd0);
      checkOutput("halted_jal",   32'(oJal),    32'd0);
      checkOutput("halted_flag",  32'(oHalt),   32'd1);
      checkOutput("halted_rd",    32'(oRdAddr), 32'd31);
      checkOutput("halted_alu",   oAluResult,   32'h0000_0100);
      checkOutput("halted_count", oCount,       32'd11);
    end
    enable = 1'b0;
    applyStimulus();
    checkOutput("halted_hold_flag", 32'(oHalt), 32'd1);

    // Reset mid-halt clears everything on that edge.
    reset = 1'b1;
    applyStimulus();
    checkOutput("rst2_halt",  32'(oHalt),   32'd0);
    checkOutput("rst2_count", oCount,       32'd0);
    checkOutput("rst2_rd",    32'(oRdAddr), 32'd0);

    // Counter wrap: 17 valid captures on a 4-bit counter leaves 1.
    reset = 1'b0; enable = 1'b1;
    setOp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h0000_0001);
    for (int i = 0; i < 17; i++) applyStimulus();
    checkOutput("wrap_count4",  32'(wCount), 32'd1);
    checkOutput("wrap_count32", oCount,      32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
